// File: rtl/stopwatch_core_ext.sv
// stopwatch_core_ext
// Up/down centisecond timer: minutes / seconds / 10 ms fields driven by an
// internal prescaler tick, with saturating preset load, synchronous clear,
// lap capture, up-count rollover pulse and a countdown-complete flag.
//
// Ports:
//   clk_core        sole clock, rising edge
//   rst             asynchronous active-low reset
//   en              run enable; low freezes prescaler and fields
//   dir             0 = count up, 1 = count down
//   clr             synchronous clear (highest priority)
//   load            synchronous preset from ld_min/ld_sec/ld_cs (saturated)
//   ld_min/sec/cs   preset values
//   lap             capture request; snapshot of pre-edge live fields
//   min_o/sec_o/ms_10_o              live fields
//   lap_min_o/lap_sec_o/lap_ms_10_o  captured fields
//   lap_valid_o     one-cycle pulse after a capture
//   wrap_o          one-cycle pulse after an up-count rollover
//   done_o          level, set once a countdown reaches 00:00:00
module stopwatch_core_ext #(
  parameter int TICK_DIV = 500000,
  parameter int MIN_MAX  = 59
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       clr,
  input  logic       load,
  input  logic [5:0] ld_min,
  input  logic [5:0] ld_sec,
  input  logic [6:0] ld_cs,
  input  logic       lap,
  output logic [5:0] min_o,
  output logic [5:0] sec_o,
  output logic [6:0] ms_10_o,
  output logic [5:0] lap_min_o,
  output logic [5:0] lap_sec_o,
  output logic [6:0] lap_ms_10_o,
  output logic       lap_valid_o,
  output logic       wrap_o,
  output logic       done_o
);

  // A one-bit prescaler is kept even for TICK_DIV=1; it then stays at 0.
  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]    MIN_LIM    = 6'(MIN_MAX);
  localparam logic [5:0]    SEC_LIM    = 6'd59;
  localparam logic [6:0]    CS_LIM     = 7'd99;

  logic [PW-1:0] presc_reg, presc_next;
  logic [5:0]    min_reg, min_next;
  logic [5:0]    sec_reg, sec_next;
  logic [6:0]    cs_reg, cs_next;
  logic [5:0]    lap_min_reg, lap_min_next;
  logic [5:0]    lap_sec_reg, lap_sec_next;
  logic [6:0]    lap_cs_reg, lap_cs_next;
  logic          lap_valid_reg, lap_valid_next;
  logic          wrap_reg, wrap_next;
  logic          done_reg, done_next;
  logic          tick;
  logic          halted;

  // A finished countdown parks the prescaler until dir returns to 0.
  assign halted = dir & done_reg;

  always_comb begin
    presc_next     = presc_reg;
    min_next       = min_reg;
    sec_next       = sec_reg;
    cs_next        = cs_reg;
    done_next      = done_reg;
    wrap_next      = 1'b0;
    lap_min_next   = lap_min_reg;
    lap_sec_next   = lap_sec_reg;
    lap_cs_next    = lap_cs_reg;
    lap_valid_next = 1'b0;
    tick           = 1'b0;

    if (clr) begin
      presc_next = '0;
      min_next   = '0;
      sec_next   = '0;
      cs_next    = '0;
      done_next  = 1'b0;
    end else if (load) begin
      min_next   = (ld_min > MIN_LIM) ? MIN_LIM : ld_min;
      sec_next   = (ld_sec > SEC_LIM) ? SEC_LIM : ld_sec;
      cs_next    = (ld_cs  > CS_LIM)  ? CS_LIM  : ld_cs;
      presc_next = '0;
      done_next  = 1'b0;
    end else begin
      if (en && !halted) begin
        if (presc_reg == PRESC_LAST) begin
          presc_next = '0;
          tick       = 1'b1;
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end

      if (!dir) begin
        done_next = 1'b0;
      end

      if (tick && !dir) begin
        if (cs_reg < CS_LIM) begin
          cs_next = cs_reg + 7'd1;
        end else if (sec_reg < SEC_LIM) begin
          sec_next = sec_reg + 6'd1;
          cs_next  = '0;
        end else if (min_reg < MIN_LIM) begin
          min_next = min_reg + 6'd1;
          sec_next = '0;
          cs_next  = '0;
        end else begin
          min_next  = '0;
          sec_next  = '0;
          cs_next   = '0;
          wrap_next = 1'b1;
        end
      end else if (tick && dir) begin
        if (cs_reg != '0) begin
          cs_next = cs_reg - 7'd1;
        end else if (sec_reg != '0) begin
          sec_next = sec_reg - 6'd1;
          cs_next  = CS_LIM;
        end else if (min_reg != '0) begin
          min_next = min_reg - 6'd1;
          sec_next = SEC_LIM;
          cs_next  = CS_LIM;
        end
        // Also covers a tick while already at zero: fields hold, flag sets.
        if (min_next == '0 && sec_next == '0 && cs_next == '0) begin
          done_next = 1'b1;
        end
      end
    end

    // Lap snapshot uses the pre-edge live fields; clear overrides capture.
    if (clr) begin
      lap_min_next = '0;
      lap_sec_next = '0;
      lap_cs_next  = '0;
    end else if (lap) begin
      lap_min_next   = min_reg;
      lap_sec_next   = sec_reg;
      lap_cs_next    = cs_reg;
      lap_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      presc_reg     <= '0;
      min_reg       <= '0;
      sec_reg       <= '0;
      cs_reg        <= '0;
      lap_min_reg   <= '0;
      lap_sec_reg   <= '0;
      lap_cs_reg    <= '0;
      lap_valid_reg <= 1'b0;
      wrap_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      presc_reg     <= presc_next;
      min_reg       <= min_next;
      sec_reg       <= sec_next;
      cs_reg        <= cs_next;
      lap_min_reg   <= lap_min_next;
      lap_sec_reg   <= lap_sec_next;
      lap_cs_reg    <= lap_cs_next;
      lap_valid_reg <= lap_valid_next;
      wrap_reg      <= wrap_next;
      done_reg      <= done_next;
    end
  end

  assign min_o       = min_reg;
  assign sec_o       = sec_reg;
  assign ms_10_o     = cs_reg;
  assign lap_min_o   = lap_min_reg;
  assign lap_sec_o   = lap_sec_reg;
  assign lap_ms_10_o = lap_cs_reg;
  assign lap_valid_o = lap_valid_reg;
  assign wrap_o      = wrap_reg;
  assign done_o      = done_reg;

endmodule

// File: tb/tb_stopwatch_core_ext.sv
// Bench for stopwatch_core_ext. Two instances share one stimulus stream:
//   index 0: TICK_DIV=4, MIN_MAX=59
//   index 1: TICK_DIV=1, MIN_MAX=2
// The reference model keeps time as a single centisecond total per instance.
module tb_stopwatch_core_ext;

  logic       clk_core = 1'b0;
  logic       rst;
  logic       en, dir, clr, load, lap;
  logic [5:0] ld_min, ld_sec;
  logic [6:0] ld_cs;

  logic [5:0] o_min[2];
  logic [5:0] o_sec[2];
  logic [6:0] o_cs[2];
  logic [5:0] o_lmin[2];
  logic [5:0] o_lsec[2];
  logic [6:0] o_lcs[2];
  logic       o_lv[2];
  logic       o_wrap[2];
  logic       o_done[2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_core = ~clk_core;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      stopwatch_core_ext #(
        .TICK_DIV((gi == 0) ? 4 : 1),
        .MIN_MAX ((gi == 0) ? 59 : 2)
      ) dut (
        .clk_core   (clk_core),
        .rst        (rst),
        .en         (en),
        .dir        (dir),
        .clr        (clr),
        .load       (load),
        .ld_min     (ld_min),
        .ld_sec     (ld_sec),
        .ld_cs      (ld_cs),
        .lap        (lap),
        .min_o      (o_min[gi]),
        .sec_o      (o_sec[gi]),
        .ms_10_o    (o_cs[gi]),
        .lap_min_o  (o_lmin[gi]),
        .lap_sec_o  (o_lsec[gi]),
        .lap_ms_10_o(o_lcs[gi]),
        .lap_valid_o(o_lv[gi]),
        .wrap_o     (o_wrap[gi]),
        .done_o     (o_done[gi])
      );
    end
  endgenerate

  // ---------------- reference model ----------------
  function automatic int td(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int mm(input int i);
    return (i == 0) ? 59 : 2;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // centisecond total -> mmsscc decimal, for readable comparisons
  function automatic int enc(input int t);
    return (t / 6000) * 10000 + ((t / 100) % 60) * 100 + (t % 100);
  endfunction

  function automatic int now_time(input int i);
    return int'(o_min[i]) * 10000 + int'(o_sec[i]) * 100 + int'(o_cs[i]);
  endfunction

  function automatic int lap_time(input int i);
    return int'(o_lmin[i]) * 10000 + int'(o_lsec[i]) * 100 + int'(o_lcs[i]);
  endfunction

  int m_total[2];
  int m_pc[2];
  bit m_done[2];
  bit m_wrap[2];
  int m_lap[2];
  bit m_lv[2];

  always @(posedge clk_core or negedge rst) begin : model
    int t, pc, lt, tmax;
    bit dn, wr, tk, lv;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_total[i] <= 0;
        m_pc[i]    <= 0;
        m_done[i]  <= 1'b0;
        m_wrap[i]  <= 1'b0;
        m_lap[i]   <= 0;
        m_lv[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        t    = m_total[i];
        pc   = m_pc[i];
        dn   = m_done[i];
        lt   = m_lap[i];
        wr   = 1'b0;
        tk   = 1'b0;
        lv   = 1'b0;
        tmax = mm(i) * 6000 + 5999;
        if (clr) begin
          t = 0; pc = 0; dn = 1'b0;
        end else if (load) begin
          t = min_i(int'(ld_min), mm(i)) * 6000 + min_i(int'(ld_sec), 59) * 100
              + min_i(int'(ld_cs), 99);
          pc = 0; dn = 1'b0;
        end else begin
          if (en && !(dir && dn)) begin
            pc = pc + 1;
            if (pc == td(i)) begin
              pc = 0;
              tk = 1'b1;
            end
          end
          if (!dir) dn = 1'b0;
          if (tk && !dir) begin
            if (t == tmax) begin
              t = 0; wr = 1'b1;
            end else begin
              t = t + 1;
            end
          end else if (tk && dir) begin
            if (t > 0) t = t - 1;
            if (t == 0) dn = 1'b1;
          end
        end
        if (clr) begin
          lt = 0;
        end else if (lap) begin
          lt = m_total[i];
          lv = 1'b1;
        end
        m_total[i] <= t;
        m_pc[i]    <= pc;
        m_done[i]  <= dn;
        m_wrap[i]  <= wr;
        m_lap[i]   <= lt;
        m_lv[i]    <= lv;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", name, idx, act, exp, $time);
    end
  endtask

  always @(negedge clk_core) begin
    for (int i = 0; i < 2; i++) begin
      chk("time",      i, now_time(i),     enc(m_total[i]));
      chk("lap_time",  i, lap_time(i),     enc(m_lap[i]));
      chk("lap_valid", i, int'(o_lv[i]),   int'(m_lv[i]));
      chk("wrap",      i, int'(o_wrap[i]), int'(m_wrap[i]));
      chk("done",      i, int'(o_done[i]), int'(m_done[i]));
    end
  end

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_time"},  i, now_time(i), 0);
      chk({tag, "_lap"},   i, lap_time(i), 0);
      chk({tag, "_flags"}, i, int'(o_lv[i]) + int'(o_wrap[i]) + int'(o_done[i]), 0);
    end
  endtask

  task automatic edge1();
    @(posedge clk_core);
    #1;
  endtask

  task automatic set_ld(input int m, input int s, input int c);
    ld_min = 6'(m);
    ld_sec = 6'(s);
    ld_cs  = 7'(c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1; en = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0; lap = 1'b0;
    set_ld(0, 0, 0);
    #1 rst = 1'b0;
    #3;
    chk_zero("reset");

    // Up count cadence: TICK_DIV=4 ticks on enabled cycles 4, 8, ...
    @(negedge clk_core);
    #1;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk_core);
    #1;
    chk("cadence_pre", 0, now_time(0), 0);
    edge1();
    chk("cadence_first", 0, now_time(0), 1);
    repeat (396) @(posedge clk_core);
    #1;
    chk("after400", 0, now_time(0), 100);   // 00:01:00
    chk("after400", 1, now_time(1), 400);   // 00:04:00 at one tick per cycle

    // Rollover at MIN_MAX=2 from 02:59:98
    en = 1'b0; load = 1'b1; set_ld(2, 59, 98);
    edge1();
    chk("load_wrap_start", 1, now_time(1), 25998);
    load = 1'b0; en = 1'b1;
    edge1();
    chk("wrap_step1", 1, now_time(1), 25999);
    chk("wrap_pre", 1, int'(o_wrap[1]), 0);
    edge1();
    chk("wrap_step2", 1, now_time(1), 0);
    chk("wrap_pulse", 1, int'(o_wrap[1]), 1);
    en = 1'b0;
    edge1();
    chk("wrap_width", 1, int'(o_wrap[1]), 0);

    // Countdown from 01:00:01
    dir = 1'b1; load = 1'b1; set_ld(1, 0, 1);
    edge1();
    load = 1'b0; en = 1'b1;
    edge1();
    chk("down1", 1, now_time(1), 10000);
    edge1();
    chk("down2", 1, now_time(1), 5999);
    n = 2;
    while (o_done[1] == 1'b0 && n < 7000) begin
      edge1();
      n++;
    end
    chk("down_ticks", 1, n, 6001);
    chk("down_zero", 1, now_time(1), 0);
    chk("down_done", 1, int'(o_done[1]), 1);
    repeat (3) edge1();
    chk("halt_zero", 1, now_time(1), 0);
    chk("halt_done", 1, int'(o_done[1]), 1);
    dir = 1'b0;
    edge1();
    chk("resume_done", 1, int'(o_done[1]), 0);
    chk("resume_up", 1, now_time(1), 1);

    // Saturating load
    en = 1'b0; load = 1'b1; set_ld(63, 60, 127);
    edge1();
    chk("sat_load", 0, now_time(0), 595999);
    chk("sat_load", 1, now_time(1), 25999);

    // Lap capture at 00:12:34 while running
    set_ld(0, 12, 34);
    edge1();
    load = 1'b0; en = 1'b1; lap = 1'b1;
    edge1();
    chk("lap_capture", 1, lap_time(1), 1234);
    chk("lap_capture", 0, lap_time(0), 1234);
    chk("lap_valid_hi", 1, int'(o_lv[1]), 1);
    chk("lap_live", 1, now_time(1), 1235);
    lap = 1'b0;
    edge1();
    chk("lap_valid_lo", 1, int'(o_lv[1]), 0);
    chk("lap_hold", 1, lap_time(1), 1234);
    chk("lap_live2", 1, now_time(1), 1236);

    // Asynchronous reset mid-cycle
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    #2 rst = 1'b1;

    // clr + load + lap on one edge
    edge1();
    lap = 1'b1;
    edge1();
    chk("pre_clr_lv", 1, int'(o_lv[1]), 1);
    clr = 1'b1; load = 1'b1; set_ld(5, 5, 5);
    edge1();
    chk_zero("clr_load_lap");
    clr = 1'b0; load = 1'b0; lap = 1'b0;

    // Randomized phase
    for (int k = 0; k < 4000; k++) begin
      en   = ($urandom_range(0, 99) < 85);
      clr  = ($urandom_range(0, 199) < 3);
      load = ($urandom_range(0, 99) < 3);
      lap  = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 3) dir = ~dir;
      if ($urandom_range(0, 1) == 0) set_ld(0, $urandom_range(0, 5), $urandom_range(0, 127));
      else set_ld($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 127));
      edge1();
    end
    en = 1'b0; clr = 1'b0; load = 1'b0; lap = 1'b0;
    edge1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
